// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between requesters and rr_lock_arbiter.
// Optional feature macro: ARB_STARVE_MON_EN adds the per-port starve_o flags.
// Handshake: req_i bits are level requests held by each requester; gnt_o is a
// registered one-hot grant, and a requester owns the bus for every cycle its
// gnt_o bit is high. It gives ownership up by dropping its req_i bit.
interface rr_lock_arbiter_if #(
    parameter int NUM_PORTS = 8
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] req_i;
    logic                 mode_i;
    logic [NUM_PORTS-1:0] gnt_o;
    logic                 gnt_valid_o;
    logic [IDX_W-1:0]     gnt_idx_o;
    logic                 state_dbg;    // 1 = GRANT, 0 = IDLE
`ifdef ARB_STARVE_MON_EN
    logic [NUM_PORTS-1:0] starve_o;
`endif

    modport master (
        output req_i, mode_i,
        input  gnt_o, gnt_valid_o, gnt_idx_o, state_dbg
`ifdef ARB_STARVE_MON_EN
        , input starve_o
`endif
    );

    modport slave (
        input  req_i, mode_i,
        output gnt_o, gnt_valid_o, gnt_idx_o, state_dbg
`ifdef ARB_STARVE_MON_EN
        , output starve_o
`endif
    );
endinterface

// File: rtl/rr_lock_arbiter.sv
// N-port arbiter with fixed-priority or round-robin policy and a registered
// one-hot grant. The owner keeps the grant while it requests, up to MAX_HOLD
// cycles when others are waiting.
// Optional feature macro: ARB_STARVE_MON_EN adds per-port wait counters and the
// starve_o flags.
module rr_lock_arbiter #(
    parameter int NUM_PORTS    = 8,
    parameter int MAX_HOLD     = 16,
    parameter int STARVE_LIMIT = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    rr_lock_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_PORTS);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;

    logic [NUM_PORTS-1:0] cand;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic                 take;

    // Winner search over every requester except the current owner; the owner
    // either dropped its request or is being forced out, so it never competes.
    always_comb begin
        int start;
        int j;
        cand      = bus.req_i & ~gnt_q;
        win_idx   = '0;
        win_found = 1'b0;
        start     = bus.mode_i ? int'(rr_ptr_q) : 0;
        j         = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = start + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, on owner release, or on hold timeout.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) take = 1'b1;
            end
            GRANT: begin
                if (!bus.req_i[idx_q]) begin
                    if (win_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        hold_d  = '0;
                    end
                end else if (MAX_HOLD != 0 && hold_q >= HOLD_W'(MAX_HOLD) && win_found) begin
                    take = 1'b1;
                end else if (MAX_HOLD != 0 && hold_q < HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = GRANT;
            gnt_d   = NUM_PORTS'(1) << win_idx;
            idx_d   = win_idx;
            hold_d  = HOLD_W'(1);
            // Pointer moves in both modes so a mode switch sees a fresh rotation.
            rr_ptr_d = (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = |gnt_q;
    assign bus.gnt_idx_o   = idx_q;
    assign bus.state_dbg   = (state_q == GRANT);

`ifdef ARB_STARVE_MON_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [NUM_PORTS-1:0][SW-1:0] wait_q, wait_d;
    logic [NUM_PORTS-1:0]         starve_q, starve_d;

    // Wait counters clear on the edge a port is granted or drops its request.
    always_comb begin
        wait_d   = wait_q;
        starve_d = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!bus.req_i[k] || gnt_d[k]) begin
                wait_d[k] = '0;
            end else if (wait_q[k] != SW'(STARVE_LIMIT)) begin
                wait_d[k] = wait_q[k] + 1'b1;
            end
            starve_d[k] = (wait_d[k] == SW'(STARVE_LIMIT));
        end
    end

    // Starvation monitor registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q   <= '0;
            starve_q <= '0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    assign bus.starve_o = starve_q;
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_LIMIT > 0);
`endif
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: three instances cover NUM_PORTS=4 with
// MAX_HOLD=4, NUM_PORTS=4 with MAX_HOLD=0, and NUM_PORTS=5 with MAX_HOLD=4.
// Optional feature macro: ARB_STARVE_MON_EN enables the starvation checks.
module tb_rr_lock_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] exp_q[$];

    rr_lock_arbiter_if #(.NUM_PORTS(4)) bus4 ();
    rr_lock_arbiter_if #(.NUM_PORTS(4)) bus0 ();
    rr_lock_arbiter_if #(.NUM_PORTS(5)) bus5 ();

    rr_lock_arbiter #(.NUM_PORTS(4), .MAX_HOLD(4), .STARVE_LIMIT(8)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));
    rr_lock_arbiter #(.NUM_PORTS(4), .MAX_HOLD(0), .STARVE_LIMIT(8)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
    rr_lock_arbiter #(.NUM_PORTS(5), .MAX_HOLD(4), .STARVE_LIMIT(8)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus5.slave));

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance one active edge, then park on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] e4;
        logic [4:0] e5;
        rst_n = 1'b0;
        bus4.req_i = 4'hF; bus4.mode_i = 1'b0;
        bus0.req_i = 4'h0; bus0.mode_i = 1'b0;
        bus5.req_i = 5'h0; bus5.mode_i = 1'b0;

        // Reset held with all requests active.
        step();
        step();
        check("rst_gnt", bus4.gnt_o, 4'b0000);
        check("rst_valid", bus4.gnt_valid_o, 1'b0);
        check("rst_state", bus4.state_dbg, 1'b0);
        rst_n = 1'b1;
        step();
        check("rel_gnt", bus4.gnt_o, 4'b0001);
        check("rel_idx", bus4.gnt_idx_o, 2'd0);
        check("rel_valid", bus4.gnt_valid_o, 1'b1);
        // Asynchronous reset mid-grant, no clock edge in between.
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt", bus4.gnt_o, 4'b0000);
        check("async_valid", bus4.gnt_valid_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus4.req_i = 4'h0;
        step();

        // Fixed priority, back-to-back handover with no idle cycle.
        bus4.mode_i = 1'b0;
        bus4.req_i  = 4'b1010;
        step();
        check("fix_gnt1", bus4.gnt_o, 4'b0010);
        step();
        check("fix_gnt2", bus4.gnt_o, 4'b0010);
        bus4.req_i = 4'b1000;
        step();
        check("fix_b2b", bus4.gnt_o, 4'b1000);
        check("fix_idx", bus4.gnt_idx_o, 2'd3);
        bus4.req_i = 4'b0000;
        step();
        check("fix_idle", bus4.gnt_o, 4'b0000);
        check("fix_idle_valid", bus4.gnt_valid_o, 1'b0);

        // Round robin: each owner drops its request for one cycle.
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus4.mode_i = 1'b1;
        bus4.req_i  = 4'hF;
        while (exp_q.size() > 0) begin
            e4 = exp_q.pop_front();
            step();
            check("rr_order", bus4.gnt_o, e4);
            bus4.req_i = 4'hF & ~e4;
        end
        bus4.req_i = 4'h0;
        step();

        // Hold timeout alternation; unlimited hold on the MAX_HOLD=0 instance.
        do_reset();
        bus4.mode_i = 1'b1; bus4.req_i = 4'b0011;
        bus0.mode_i = 1'b1; bus0.req_i = 4'b0011;
        for (int e = 0; e < 12; e++) begin
            step();
            e4 = (((e / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
            check("hold_alt", bus4.gnt_o, e4);
            check("hold_inf", bus0.gnt_o, 4'b0001);
        end
        bus4.req_i = 4'h0;
        bus0.req_i = 4'h0;
        step();

        // Pointer wrap on a 5-port arbiter.
        do_reset();
        bus5.mode_i = 1'b1;
        bus5.req_i  = 5'b01000;
        step();
        check("wrap_pre", bus5.gnt_o, 5'b01000);
        bus5.req_i = 5'b10001;
        for (int e = 1; e <= 5; e++) begin
            step();
            e5 = (e <= 4) ? 5'b10000 : 5'b00001;
            check("wrap_gnt", bus5.gnt_o, e5);
            check("wrap_idx", bus5.gnt_idx_o, (e <= 4) ? 3'd4 : 3'd0);
        end
        bus5.req_i = 5'h0;
        step();

`ifdef ARB_STARVE_MON_EN
        // Starvation flag with an owner that never releases.
        do_reset();
        bus0.mode_i = 1'b0;
        bus0.req_i  = 4'b0001;
        step();
        check("stv_own", bus0.gnt_o, 4'b0001);
        check("stv_init", bus0.starve_o, 4'b0000);
        bus0.req_i = 4'b0101;
        for (int e = 1; e <= 8; e++) begin
            step();
            check("stv_flag", bus0.starve_o, (e == 8) ? 4'b0100 : 4'b0000);
        end
        bus0.req_i = 4'b0100;
        step();
        check("stv_gnt", bus0.gnt_o, 4'b0100);
        check("stv_clear", bus0.starve_o, 4'b0000);
        bus0.req_i = 4'h0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
